instruction_fd_ctrl: RTL and testbench

Multicycle control unit that sequences the Instruction_FD fetch/decode/execute datapath. It owns the program counter and fetches one instruction per pass. It decodes the RV64 subset ld/sd/add/sub/addi/ecall and generates one-cycle write strobes plus the held mux/ALU selects that the datapath consumes. It replaces hand-driven control in benches and is the top-level sequencer of the processor.

---
 rtl/instruction_fd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_instruction_fd_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fd_ctrl.sv
// Multicycle sequencer for the Instruction_FD datapath: owns the PC, fetches, decodes the
// RV64 ld/sd/add/sub/addi/ecall subset and issues one-cycle write strobes plus held selects.
module instruction_fd_ctrl #(
   parameter int unsigned          PC_W     = 32,
   parameter logic [PC_W-1:0]      PC_START = '0,
   parameter int unsigned          PC_STEP  = 1,
   parameter int unsigned          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      instruction,
   output logic [PC_W-1:0]  PC_add,
   output logic             PC_load,
   output logic [1:0]       OP_MEM_I,
   output logic             ADD_SUB,
   output logic             WE_reg,
   output logic             WE_mem,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count,
   output logic [2:0]       state_out
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StHalt   = 3'd6
   } state_e;

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [31:0]      ir_q, ir_d;
   logic [1:0]       op_q, op_d;
   logic             sub_q, sub_d;
   logic             is_mem_q, is_mem_d;
   logic             is_st_q, is_st_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       dec_ld, dec_sd, dec_r, dec_addi, dec_ecall;

   assign opcode    = ir_q[6:0];
   assign funct3    = ir_q[14:12];
   assign dec_ld    = (opcode == 7'b0000011) && (funct3 == 3'b011);
   assign dec_sd    = (opcode == 7'b0100011) && (funct3 == 3'b011);
   assign dec_r     = (opcode == 7'b0110011) && (funct3 == 3'b000);
   assign dec_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
   assign dec_ecall = (ir_q == 32'h0000_0073);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      op_d      = op_q;
      sub_d     = sub_q;
      is_mem_d  = is_mem_q;
      is_st_d   = is_st_q;
      illegal_d = illegal_q;
      cnt_d     = cnt_q;
      PC_load   = 1'b0;
      WE_reg    = 1'b0;
      WE_mem    = 1'b0;
      retire    = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) state_d = StFetch;
         end
         StFetch: begin
            PC_load = 1'b1;
            ir_d    = instruction;
            state_d = StDecode;
         end
         StDecode: begin
            state_d = StExec;
            if (dec_ld || dec_sd) begin
               op_d     = 2'd1;
               sub_d    = 1'b0;
               is_mem_d = 1'b1;
               is_st_d  = dec_sd;
            end else if (dec_r) begin
               op_d     = 2'd0;
               sub_d    = ir_q[30];
               is_mem_d = 1'b0;
               is_st_d  = 1'b0;
            end else if (dec_addi) begin
               op_d     = 2'd2;
               sub_d    = 1'b0;
               is_mem_d = 1'b0;
               is_st_d  = 1'b0;
            end else begin
               state_d   = StHalt;
               illegal_d = !dec_ecall;
            end
         end
         StExec: begin
            state_d = is_mem_q ? StMem : StWb;
         end
         StMem: begin
            if (is_st_q) begin
               WE_mem = 1'b1;
               retire = 1'b1;
            end else begin
               state_d = StWb;
            end
         end
         StWb: begin
            // rd == x0 suppresses the write but still retires
            WE_reg = (ir_q[11:7] != 5'd0);
            retire = 1'b1;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Selects drop back to 0 so they read inactive during the following fetch
      if (retire) begin
         state_d = StFetch;
         pc_d    = pc_q + PC_W'(PC_STEP);
         cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
         op_d    = 2'd0;
         sub_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pc_q      <= PC_START;
         ir_q      <= '0;
         op_q      <= '0;
         sub_q     <= 1'b0;
         is_mem_q  <= 1'b0;
         is_st_q   <= 1'b0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         op_q      <= op_d;
         sub_q     <= sub_d;
         is_mem_q  <= is_mem_d;
         is_st_q   <= is_st_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign PC_add      = pc_q;
   assign OP_MEM_I    = op_q;
   assign ADD_SUB     = sub_q;
   assign halted      = (state_q == StHalt);
   assign illegal     = illegal_q;
   assign instr_count = cnt_q;
   assign state_out   = state_q;

endmodule

// File: tb/tb_instruction_fd_ctrl.sv
// Directed bench for instruction_fd_ctrl with a small behavioural datapath driven by its strobes.
module tb_instruction_fd_ctrl;

   localparam int unsigned PC_W  = 32;
   localparam int unsigned CNT_W = 16;

   localparam logic [31:0] I_LD1  = 32'h0010_3083;
   localparam logic [31:0] I_LD2  = 32'h0020_3103;
   localparam logic [31:0] I_ADD  = 32'h0020_81B3;
   localparam logic [31:0] I_SUB  = 32'h4011_8233;
   localparam logic [31:0] I_SD   = 32'h0030_31A3;
   localparam logic [31:0] I_ECL  = 32'h0000_0073;
   localparam logic [31:0] I_ADD0 = 32'h0020_8033;
   localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [31:0]      instruction;
   logic [PC_W-1:0]  PC_add;
   logic             PC_load;
   logic [1:0]       OP_MEM_I;
   logic             ADD_SUB;
   logic             WE_reg;
   logic             WE_mem;
   logic             halted;
   logic             illegal;
   logic [CNT_W-1:0] instr_count;
   logic [2:0]       state_out;

   int errors = 0;
   int checks = 0;

   instruction_fd_ctrl #(
      .PC_W    (PC_W),
      .PC_START('0),
      .PC_STEP (1),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .instruction(instruction),
      .PC_add     (PC_add),
      .PC_load    (PC_load),
      .OP_MEM_I   (OP_MEM_I),
      .ADD_SUB    (ADD_SUB),
      .WE_reg     (WE_reg),
      .WE_mem     (WE_mem),
      .halted     (halted),
      .illegal    (illegal),
      .instr_count(instr_count),
      .state_out  (state_out)
   );

   always #5 clk = ~clk;

   // Behavioural datapath: instruction memory, register file, data memory
   logic [31:0] imem [16];
   logic [63:0] rf   [32];
   logic [63:0] dmem [16];
   logic [31:0] tb_ir;
   logic        clr;
   logic [63:0] rs1v, rs2v, iimm, simm, ld_addr, st_addr, wb_val;

   assign instruction = imem[PC_add[3:0]];

   always_comb begin
      rs1v    = rf[tb_ir[19:15]];
      rs2v    = rf[tb_ir[24:20]];
      iimm    = {{52{tb_ir[31]}}, tb_ir[31:20]};
      simm    = {{52{tb_ir[31]}}, tb_ir[31:25], tb_ir[11:7]};
      ld_addr = rs1v + iimm;
      st_addr = rs1v + simm;
      case (OP_MEM_I)
         2'd1:    wb_val = dmem[ld_addr[3:0]];
         2'd2:    wb_val = rs1v + iimm;
         default: wb_val = ADD_SUB ? (rs1v - rs2v) : (rs1v + rs2v);
      endcase
   end

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
         for (int i = 0; i < 16; i++) dmem[i] <= '0;
         dmem[1] <= 64'd10;
         dmem[2] <= 64'd20;
         tb_ir   <= '0;
      end else begin
         if (PC_load) tb_ir <= instruction;
         if (WE_reg) rf[tb_ir[11:7]] <= wb_val;
         if (WE_mem) dmem[st_addr[3:0]] <= rs2v;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      clr   = 1'b1;
      for (int i = 0; i < 16; i++) imem[i] = I_ECL;
      tick();
      tick();
      rst_n = 1'b1;
      clr   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      int strobe_hits = 0;
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (state_out !== 3'd0 || PC_add !== 32'd0 || instr_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: state=%0d pc=%0d cnt=%0d want 0/0/0",
                  state_out, PC_add, instr_count);
      end
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (PC_load || WE_reg || WE_mem || halted || illegal || OP_MEM_I != 2'd0 || ADD_SUB)
            strobe_hits++;
         tick();
      end
      checks++;
      if (strobe_hits !== 0) begin
         errors++;
         $display("FAIL idle_strobes: active cycles=%0d want 0", strobe_hits);
      end
      checks++;
      if (state_out !== 3'd0 || PC_add !== 32'd0) begin
         errors++;
         $display("FAIL idle_hold: state=%0d pc=%0d want 0/0", state_out, PC_add);
      end
   endtask

   task automatic test_ld();
      logic [2:0] st_exp [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
      logic [1:0] op_exp [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      logic       we_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       pl_exp [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      imem[0] = I_LD1;
      pulse_start();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (state_out !== st_exp[c] || OP_MEM_I !== op_exp[c] || WE_reg !== we_exp[c] ||
             PC_load !== pl_exp[c] || WE_mem !== 1'b0) begin
            errors++;
            $display("FAIL ld_cycle%0d: st=%0d op=%0d wer=%b pl=%b wem=%b want %0d/%0d/%b/%b/0",
                     c + 1, state_out, OP_MEM_I, WE_reg, PC_load, WE_mem,
                     st_exp[c], op_exp[c], we_exp[c], pl_exp[c]);
         end
         tick();
      end
      checks++;
      if (PC_add !== 32'd1 || instr_count !== 16'd1 || OP_MEM_I !== 2'd0 || state_out !== 3'd1) begin
         errors++;
         $display("FAIL ld_retire: pc=%0d cnt=%0d op=%0d st=%0d want 1/1/0/1",
                  PC_add, instr_count, OP_MEM_I, state_out);
      end
      checks++;
      if (rf[1] !== 64'd10) begin
         errors++;
         $display("FAIL ld_value: x1=%0d want 10", rf[1]);
      end
   endtask

   task automatic test_program();
      int sub_cycles = 0;
      int bad = 0;
      do_reset();
      imem[0] = I_LD1;
      imem[1] = I_LD2;
      imem[2] = I_ADD;
      imem[3] = I_SUB;
      imem[4] = I_SD;
      imem[5] = I_ECL;
      pulse_start();
      for (int i = 0; i < 60 && !halted; i++) begin
         if (ADD_SUB) sub_cycles++;
         if (ADD_SUB && tb_ir !== I_SUB) bad++;
         if (WE_reg && WE_mem) bad++;
         tick();
      end
      checks++;
      if (halted !== 1'b1 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL prog_halt: halted=%b illegal=%b want 1/0", halted, illegal);
      end
      checks++;
      if (PC_add !== 32'd5 || instr_count !== 16'd5) begin
         errors++;
         $display("FAIL prog_pc_cnt: pc=%0d cnt=%0d want 5/5", PC_add, instr_count);
      end
      checks++;
      if (rf[3] !== 64'd30 || rf[4] !== 64'd20 || dmem[3] !== 64'd30) begin
         errors++;
         $display("FAIL prog_data: x3=%0d x4=%0d mem3=%0d want 30/20/30", rf[3], rf[4], dmem[3]);
      end
      checks++;
      if (sub_cycles !== 2 || bad !== 0) begin
         errors++;
         $display("FAIL prog_addsub: sub cycles=%0d violations=%0d want 2/0", sub_cycles, bad);
      end
      checks++;
      if (PC_load || WE_reg || WE_mem || state_out !== 3'd6) begin
         errors++;
         $display("FAIL prog_halt_strobes: pl=%b wer=%b wem=%b st=%0d want 0/0/0/6",
                  PC_load, WE_reg, WE_mem, state_out);
      end
   endtask

   task automatic test_x0_write();
      int we_hits = 0;
      do_reset();
      imem[0] = I_ADD0;
      pulse_start();
      for (int c = 0; c < 4; c++) begin
         if (WE_reg) we_hits++;
         tick();
      end
      checks++;
      if (we_hits !== 0) begin
         errors++;
         $display("FAIL x0_we_reg: high cycles=%0d want 0", we_hits);
      end
      checks++;
      if (PC_add !== 32'd1 || instr_count !== 16'd1 || state_out !== 3'd1) begin
         errors++;
         $display("FAIL x0_retire: pc=%0d cnt=%0d st=%0d want 1/1/1", PC_add, instr_count, state_out);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      imem[0] = I_BAD;
      pulse_start();
      tick();
      tick();
      checks++;
      if (state_out !== 3'd6 || halted !== 1'b1 || illegal !== 1'b1) begin
         errors++;
         $display("FAIL illegal_halt: st=%0d halted=%b illegal=%b want 6/1/1",
                  state_out, halted, illegal);
      end
      checks++;
      if (PC_load || WE_reg || WE_mem || PC_add !== 32'd0) begin
         errors++;
         $display("FAIL illegal_strobes: pl=%b wer=%b wem=%b pc=%0d want 0/0/0/0",
                  PC_load, WE_reg, WE_mem, PC_add);
      end
      pulse_start();
      tick();
      tick();
      checks++;
      if (state_out !== 3'd6 || PC_add !== 32'd0 || instr_count !== 16'd0 || PC_load) begin
         errors++;
         $display("FAIL illegal_sticky: st=%0d pc=%0d cnt=%0d pl=%b want 6/0/0/0",
                  state_out, PC_add, instr_count, PC_load);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      imem[0] = I_ADD;
      imem[1] = I_SD;
      pulse_start();
      for (int c = 0; c < 7; c++) tick();
      checks++;
      if (state_out !== 3'd4 || WE_mem !== 1'b1 || instr_count !== 16'd1) begin
         errors++;
         $display("FAIL sd_mem_cycle: st=%0d wem=%b cnt=%0d want 4/1/1", state_out, WE_mem, instr_count);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (WE_mem !== 1'b0 || state_out !== 3'd0 || PC_add !== 32'd0 || instr_count !== 16'd0) begin
         errors++;
         $display("FAIL async_abort: wem=%b st=%0d pc=%0d cnt=%0d want 0/0/0/0",
                  WE_mem, state_out, PC_add, instr_count);
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      clr = 1'b1;
      test_reset();
      test_ld();
      test_program();
      test_x0_write();
      test_illegal();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
